// File: rtl/dmem_ctrl.sv
// M-stage data-memory req/ack controller with misalignment detection; optional hang abort under `DMEM_TIMEOUT_EN`.
// Min latency 3 cycles (IDLE->BUSY->DONE); the pipeline is stalled until the ack or abort, and a new request is never issued from DONE.
module dmem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] BE_WD,
    input  logic [3:0]  byte_enable,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        stall_mem,
    output logic [31:0] RD,
    output logic        misalign_err
`ifdef DMEM_TIMEOUT_EN
    ,
    output logic        bus_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("dmem_ctrl: TIMEOUT_CYCLES out of range 2..255");
    end

    state_t      r_state;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_be;
    logic [31:0] r_rd;

    logic        w_mem_op;
    logic        w_misalign;
    logic        w_access;
    logic        w_ack;
    logic        w_unused_f3;

    assign w_mem_op    = MemReadM | MemWriteM;
    // Only the size bits matter; funct3M[2] (unsigned-load flag) does not affect alignment.
    assign w_misalign  = w_mem_op &
                         (((funct3M[1:0] == 2'b01) & ALUResultM[0]) |
                          ((funct3M[1:0] == 2'b10) & (ALUResultM[1:0] != 2'b00)));
    assign w_access    = w_mem_op & ~w_misalign;
    assign w_ack       = mem_ack & r_mem_req;
    assign w_unused_f3 = funct3M[2];

`ifdef DMEM_TIMEOUT_EN
    logic [7:0]  r_cnt;
    logic        r_bus_err;
    logic [7:0]  w_cnt_inc;
    logic        w_timeout;

    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_timeout = (w_cnt_inc == 8'(TIMEOUT_CYCLES));
    assign bus_err   = r_bus_err;
`endif

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_be    <= 4'h0;
            r_rd        <= 32'h0;
`ifdef DMEM_TIMEOUT_EN
            r_cnt       <= 8'h0;
            r_bus_err   <= 1'b0;
`endif
        end else begin
`ifdef DMEM_TIMEOUT_EN
            r_bus_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= MemWriteM;
                        r_mem_addr  <= {ALUResultM[31:2], 2'b00};
                        r_mem_wdata <= BE_WD;
                        r_mem_be    <= MemWriteM ? byte_enable : 4'b1111;
                        r_state     <= S_BUSY;
`ifdef DMEM_TIMEOUT_EN
                        r_cnt       <= 8'h0;
`endif
                    end
                end
                S_BUSY: begin
                    // Request fields stay frozen here; only completion or abort changes them.
                    if (w_ack) begin
                        r_mem_req <= 1'b0;
                        if (!r_mem_we) begin
                            r_rd <= mem_rdata;
                        end
                        r_state <= S_DONE;
                    end
`ifdef DMEM_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_bus_err <= 1'b1;
                        if (!r_mem_we) begin
                            r_rd <= 32'h0;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
`endif
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // DONE releases the stall so the finished instruction leaves M before the next one is evaluated.
    always_comb begin
        stall_mem = 1'b0;
        case (r_state)
            S_IDLE:  stall_mem = w_access;
            S_BUSY:  stall_mem = 1'b1;
            default: stall_mem = 1'b0;
        endcase
    end

    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign mem_be       = r_mem_be;
    assign RD           = r_rd;
    assign misalign_err = w_misalign;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl: loads, stores, misalignment, back-to-back, reset abort, optional timeout.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        MemReadM, MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, BE_WD;
    logic [3:0]  byte_enable;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        stall_mem;
    logic [31:0] RD;
    logic        misalign_err;
`ifdef DMEM_TIMEOUT_EN
    logic        bus_err;
`endif

    always #5 clk = ~clk;

    dmem_ctrl #(.TIMEOUT_CYCLES(16)) u_dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .MemReadM    (MemReadM),
        .MemWriteM   (MemWriteM),
        .funct3M     (funct3M),
        .ALUResultM  (ALUResultM),
        .BE_WD       (BE_WD),
        .byte_enable (byte_enable),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .stall_mem   (stall_mem),
        .RD          (RD),
        .misalign_err(misalign_err)
`ifdef DMEM_TIMEOUT_EN
        ,
        .bus_err     (bus_err)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        MemReadM    = 1'b0;
        MemWriteM   = 1'b0;
        funct3M     = 3'b000;
        ALUResultM  = 32'h0;
        BE_WD       = 32'h0;
        byte_enable = 4'h0;
    endtask

    // Results of the most recent run_access call
    int          t_stalls, t_busy, t_errs;
    logic        t_first_req, t_stable, t_ended, t_mis, t_we;
    logic [31:0] t_addr, t_wdata, t_rd_done;
    logic [3:0]  t_be;

    // Called at posedge+1 of an IDLE cycle; holds the instruction in M until stall drops,
    // then advances the pipeline at the following edge. ack_at = BUSY cycle that acks (0 = never).
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] be, input int ack_at,
                              input logic [31:0] rdata);
        MemReadM = rd; MemWriteM = wr; funct3M = f3;
        ALUResultM = addr; BE_WD = wd; byte_enable = be;
        t_stalls = 0; t_busy = 0; t_errs = 0; t_stable = 1'b1; t_ended = 1'b0;
        t_first_req = 1'b0; t_mis = 1'b0; t_we = 1'b0;
        t_addr = 32'h0; t_wdata = 32'h0; t_be = 4'h0; t_rd_done = 32'h0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (c == 0) begin
                t_first_req = mem_req;
                t_mis       = misalign_err;
            end
`ifdef DMEM_TIMEOUT_EN
            if (bus_err) t_errs++;
`endif
            if (mem_req) begin
                t_busy++;
                if (t_busy == 1) begin
                    t_addr = mem_addr; t_be = mem_be; t_we = mem_we; t_wdata = mem_wdata;
                end else if (mem_addr !== t_addr || mem_be !== t_be ||
                             mem_we !== t_we || mem_wdata !== t_wdata) begin
                    t_stable = 1'b0;
                end
                mem_ack   = (t_busy == ack_at);
                mem_rdata = rdata;
            end
            if (!stall_mem) begin
                t_ended   = 1'b1;
                t_rd_done = RD;
                break;
            end
            t_stalls++;
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        idle_inputs();
    endtask

    initial begin
        n_rst = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req",   32'(mem_req),   32'h0);
        check("rst_we",    32'(mem_we),    32'h0);
        check("rst_addr",  mem_addr,       32'h0);
        check("rst_wdata", mem_wdata,      32'h0);
        check("rst_be",    32'(mem_be),    32'h0);
        check("rst_rd",    RD,             32'h0);
        check("rst_stall", 32'(stall_mem), 32'h0);
        @(posedge clk); #1;
        n_rst = 1'b1;

        // Non-memory instruction: no stall, no request
        ALUResultM = 32'h0000_0104; funct3M = 3'b010;
        @(negedge clk);
        check("nop_stall", 32'(stall_mem), 32'h0);
        check("nop_mis",   32'(misalign_err), 32'h0);
        @(posedge clk); #1;
        check("nop_req",   32'(mem_req), 32'h0);
        idle_inputs();

        // Aligned LW 0x104, ack on first BUSY cycle
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h5555_5555, 4'b0000, 1, 32'hDEAD_BEEF);
        check("lw_end",    32'(t_ended),  32'h1);
        check("lw_mis",    32'(t_mis),    32'h0);
        check("lw_addr",   t_addr,        32'h0000_0104);
        check("lw_be",     32'(t_be),     32'hF);
        check("lw_we",     32'(t_we),     32'h0);
        check("lw_busy",   32'(t_busy),   32'd1);
        check("lw_stalls", 32'(t_stalls), 32'd2);
        check("lw_rd",     t_rd_done,     32'hDEAD_BEEF);

        // SB 0x203, ack on fifth BUSY cycle
        run_access(1'b0, 1'b1, 3'b000, 32'h0000_0203, 32'hAB00_0000, 4'b1000, 5, 32'hBAD0_BAD0);
        check("sb_we",     32'(t_we),     32'h1);
        check("sb_addr",   t_addr,        32'h0000_0200);
        check("sb_be",     32'(t_be),     32'h8);
        check("sb_wdata",  t_wdata,       32'hAB00_0000);
        check("sb_stable", 32'(t_stable), 32'h1);
        check("sb_busy",   32'(t_busy),   32'd5);
        check("sb_stalls", 32'(t_stalls), 32'd6);
        check("sb_rd",     t_rd_done,     32'hDEAD_BEEF);

        // Misaligned LH 0x101 and LW 0x102
        run_access(1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0, 4'h0, 1, 32'h1111_1111);
        check("lh_mis",    32'(t_mis),    32'h1);
        check("lh_stalls", 32'(t_stalls), 32'd0);
        check("lh_busy",   32'(t_busy),   32'd0);
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 4'h0, 1, 32'h2222_2222);
        check("lw2_mis",    32'(t_mis),    32'h1);
        check("lw2_stalls", 32'(t_stalls), 32'd0);
        check("lw2_busy",   32'(t_busy),   32'd0);
        check("mis_rd",     RD,            32'hDEAD_BEEF);

        // LW then SW back-to-back; SW also asserts MemReadM and must still be a write
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 4'h0, 2, 32'h1234_5678);
        check("b2b_lw_rd", t_rd_done, 32'h1234_5678);
        run_access(1'b1, 1'b1, 3'b010, 32'h0000_0304, 32'hCAFE_F00D, 4'b1111, 1, 32'h9999_9999);
        check("b2b_gap",   32'(t_first_req), 32'h0);
        check("b2b_we",    32'(t_we),        32'h1);
        check("b2b_addr",  t_addr,           32'h0000_0304);
        check("b2b_stall", 32'(t_stalls),    32'd2);
        check("b2b_rd",    t_rd_done,        32'h1234_5678);

`ifdef DMEM_TIMEOUT_EN
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 4'h0, 0, 32'h7777_7777);
        check("to_end",    32'(t_ended),  32'h1);
        check("to_busy",   32'(t_busy),   32'd16);
        check("to_stalls", 32'(t_stalls), 32'd17);
        check("to_err",    32'(t_errs),   32'd1);
        check("to_rd",     t_rd_done,     32'h0);
        @(negedge clk);
        check("to_err_clr", 32'(bus_err), 32'h0);
        check("to_idle",    32'(mem_req), 32'h0);
        @(posedge clk); #1;
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 4'h0, 1, 32'h1234_5678);
`endif

        // Reset while BUSY
        MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h0000_0500;
        @(posedge clk); #1;
        check("rb_req_on", 32'(mem_req), 32'h1);
        n_rst = 1'b0;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        check("rb_req",   32'(mem_req),   32'h0);
        check("rb_stall", 32'(stall_mem), 32'h0);
        check("rb_rd",    RD,             32'h0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check("rb_ack_req",   32'(mem_req),   32'h0);
        check("rb_ack_rd",    RD,             32'h0);
        check("rb_ack_stall", 32'(stall_mem), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
